// File: rtl/mips_mdu_if.sv
// Handshake and result bus between the execute stage and the multiply/divide unit.
interface mips_mdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] rs_i;
    logic [WIDTH-1:0] rt_i;
    logic             flush_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, rs_i, rt_i, flush_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, rs_i, rt_i, flush_i,
        output busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/mips_mdu.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, then a sign-fix/commit cycle.
module mips_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    mips_mdu_if.slave  bus
);
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [DW-1:0]    acc_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] dvd_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             dz_q;
    logic             is_div_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic             muldiv_c;
    logic             accept_c;
    logic             commit_c;
    logic             wr_hi_c;
    logic             wr_lo_c;
    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [DW-1:0]    mul_next_c;
    logic [WIDTH:0]   div_shift_c;
    logic [WIDTH:0]   div_diff_c;
    logic [DW-1:0]    div_next_c;
    logic [DW-1:0]    prod_c;
    logic [WIDTH-1:0] quo_c;
    logic [WIDTH-1:0] rem_c;
    logic [WIDTH-1:0] res_hi_c;
    logic [WIDTH-1:0] res_lo_c;

    // Operand magnitudes and sign flags; op_i[0] selects the unsigned variants
    always_comb begin
        a_neg_c = ~bus.op_i[0] & bus.rs_i[WIDTH-1];
        b_neg_c = ~bus.op_i[0] & bus.rt_i[WIDTH-1];
        mag_a_c = a_neg_c ? (~bus.rs_i + WIDTH'(1)) : bus.rs_i;
        mag_b_c = b_neg_c ? (~bus.rt_i + WIDTH'(1)) : bus.rt_i;
    end

    // Iteration datapath: acc holds {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum_c   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : (WIDTH+1)'(0));
        mul_next_c  = {mul_sum_c, acc_q[WIDTH-1:1]};
        div_shift_c = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_c  = div_shift_c - {1'b0, opb_q};
        div_next_c  = div_diff_c[WIDTH]
                    ? {div_shift_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                    : {div_diff_c[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    end

    // Sign correction and divide-by-zero override applied in FIX
    always_comb begin
        prod_c = neg_q_q ? (~acc_q + DW'(1)) : acc_q;
        quo_c  = neg_q_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
        rem_c  = neg_r_q ? (~acc_q[DW-1:WIDTH] + WIDTH'(1)) : acc_q[DW-1:WIDTH];
        if (!is_div_q) begin
            res_hi_c = prod_c[DW-1:WIDTH];
            res_lo_c = prod_c[WIDTH-1:0];
        end else if (dz_q) begin
            res_hi_c = dvd_q;
            res_lo_c = '1;
        end else begin
            res_hi_c = rem_c;
            res_lo_c = quo_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state and control decode
    always_comb begin
        state_d  = state_q;
        commit_c = 1'b0;
        muldiv_c = bus.start_i & ~bus.flush_i & ~bus.op_i[2];
        accept_c = 1'b0;
        wr_hi_c  = 1'b0;
        wr_lo_c  = 1'b0;
        case (state_q)
            IDLE: begin
                accept_c = muldiv_c;
                wr_hi_c  = bus.start_i & ~bus.flush_i & (bus.op_i == OP_MTHI);
                wr_lo_c  = bus.start_i & ~bus.flush_i & (bus.op_i == OP_MTLO);
                if (muldiv_c) state_d = bus.op_i[1] ? DIV : MUL;
            end
            MUL, DIV: begin
                if (bus.flush_i)                   state_d = IDLE;
                else if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d  = IDLE;
                commit_c = ~bus.flush_i;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            dvd_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            is_div_q <= 1'b0;
        end else if (accept_c) begin
            cnt_q    <= '0;
            acc_q    <= {WIDTH'(0), bus.op_i[1] ? mag_a_c : mag_b_c};
            opb_q    <= bus.op_i[1] ? mag_b_c : mag_a_c;
            dvd_q    <= bus.rs_i;
            neg_q_q  <= a_neg_c ^ b_neg_c;
            neg_r_q  <= a_neg_c;
            dz_q     <= (bus.rt_i == '0);
            is_div_q <= bus.op_i[1];
        end else if (state_q == MUL) begin
            acc_q <= mul_next_c;
            cnt_q <= cnt_q + CW'(1);
        end else if (state_q == DIV) begin
            acc_q <= div_next_c;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Architectural HI/LO: mul/div commit or single-cycle MTHI/MTLO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= commit_c;
            if (commit_c) begin
                hi_q <= res_hi_c;
                lo_q <= res_lo_c;
            end else begin
                if (wr_hi_c) hi_q <= bus.rs_i;
                if (wr_lo_c) lo_q <= bus.rs_i;
            end
        end
    end

    assign bus.busy_o = (state_q != IDLE) | muldiv_c;
    assign bus.done_o = done_q;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;
endmodule

// File: tb/tb_mips_mdu.sv
// Directed-vector bench for mips_mdu at WIDTH=32 and WIDTH=8.
module tb_mips_mdu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mips_mdu_if #(.WIDTH(32)) bus32();
    mips_mdu_if #(.WIDTH(8))  bus8();

    mips_mdu #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    mips_mdu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a mul/div and wait for done_o; returns cycles to done and busy cycle count
    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bc);
        lat = 0;
        bc  = 0;
        bus32.start_i = 1'b1;
        bus32.op_i    = op;
        bus32.rs_i    = a;
        bus32.rt_i    = b;
        #1;
        if (bus32.busy_o) bc++;
        tick();
        bus32.start_i = 1'b0;
        bus32.rs_i    = ~a;
        bus32.rt_i    = ~b;
        lat = 1;
        #1;
        while (!bus32.done_o && lat < 100) begin
            if (bus32.busy_o) bc++;
            tick();
            #1;
            lat++;
        end
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
        lat = 0;
        bus8.start_i = 1'b1;
        bus8.op_i    = op;
        bus8.rs_i    = a;
        bus8.rt_i    = b;
        #1;
        check("w8 busy at start", 64'(bus8.busy_o), 64'd1);
        tick();
        bus8.start_i = 1'b0;
        bus8.rs_i    = ~a;
        lat = 1;
        #1;
        while (!bus8.done_o && lat < 100) begin
            tick();
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bc;
        int dcnt;
        bus32.start_i = 1'b0; bus32.op_i = 3'b111; bus32.rs_i = '0; bus32.rt_i = '0; bus32.flush_i = 1'b0;
        bus8.start_i  = 1'b0; bus8.op_i  = 3'b111; bus8.rs_i  = '0; bus8.rt_i  = '0; bus8.flush_i  = 1'b0;
        repeat (3) tick();
        check("reset hi", 64'(bus32.hi_o), 64'd0);
        check("reset lo", 64'(bus32.lo_o), 64'd0);
        check("reset done", 64'(bus32.done_o), 64'd0);
        check("reset busy", 64'(bus32.busy_o), 64'd0);
        rst = 1'b1;
        tick();

        run32(3'b000, 32'hFFFF_FFFD, 32'd5, lat, bc);
        check("mult hi", 64'(bus32.hi_o), 64'hFFFF_FFFF);
        check("mult lo", 64'(bus32.lo_o), 64'hFFFF_FFF1);
        check("mult latency", 64'(lat), 64'd34);
        check("mult busy cycles", 64'(bc), 64'd34);
        check("busy low in done cycle", 64'(bus32.busy_o), 64'd0);
        tick();
        check("done single pulse", 64'(bus32.done_o), 64'd0);

        run32(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        check("multu hi", 64'(bus32.hi_o), 64'hFFFF_FFFE);
        check("multu lo", 64'(bus32.lo_o), 64'h0000_0001);

        run32(3'b010, 32'hFFFF_FFF9, 32'd2, lat, bc);
        check("div -7/2 lo", 64'(bus32.lo_o), 64'hFFFF_FFFD);
        check("div -7/2 hi", 64'(bus32.hi_o), 64'hFFFF_FFFF);

        run32(3'b010, 32'd7, 32'hFFFF_FFFE, lat, bc);
        check("div 7/-2 lo", 64'(bus32.lo_o), 64'hFFFF_FFFD);
        check("div 7/-2 hi", 64'(bus32.hi_o), 64'h0000_0001);

        run32(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        check("div ovf lo", 64'(bus32.lo_o), 64'h8000_0000);
        check("div ovf hi", 64'(bus32.hi_o), 64'd0);

        run32(3'b011, 32'd100, 32'd7, lat, bc);
        check("divu 100/7 lo", 64'(bus32.lo_o), 64'd14);
        check("divu 100/7 hi", 64'(bus32.hi_o), 64'd2);

        run32(3'b011, 32'h0000_1234, 32'd0, lat, bc);
        check("divu /0 lo", 64'(bus32.lo_o), 64'hFFFF_FFFF);
        check("divu /0 hi", 64'(bus32.hi_o), 64'h0000_1234);
        check("divu /0 latency", 64'(lat), 64'd34);

        run32(3'b010, 32'hFFFF_FFF9, 32'd0, lat, bc);
        check("div /0 lo", 64'(bus32.lo_o), 64'hFFFF_FFFF);
        check("div /0 hi", 64'(bus32.hi_o), 64'hFFFF_FFF9);

        // MTHI / MTLO
        bus32.start_i = 1'b1; bus32.op_i = 3'b100; bus32.rs_i = 32'hA5A5_A5A5;
        #1;
        check("mthi busy", 64'(bus32.busy_o), 64'd0);
        tick();
        bus32.op_i = 3'b101; bus32.rs_i = 32'h0000_0011;
        check("mthi hi", 64'(bus32.hi_o), 64'hA5A5_A5A5);
        tick();
        bus32.start_i = 1'b0;
        check("mtlo lo", 64'(bus32.lo_o), 64'h0000_0011);
        check("mtlo no done", 64'(bus32.done_o), 64'd0);

        // Flush in IDLE suppresses both mul/div and MTHI
        bus32.start_i = 1'b1; bus32.flush_i = 1'b1; bus32.op_i = 3'b100; bus32.rs_i = 32'h1;
        tick();
        bus32.op_i = 3'b000;
        #1;
        check("idle flush busy", 64'(bus32.busy_o), 64'd0);
        tick();
        bus32.start_i = 1'b0; bus32.flush_i = 1'b0;
        #1;
        check("idle flush no accept", 64'(bus32.busy_o), 64'd0);
        check("idle flush mthi", 64'(bus32.hi_o), 64'hA5A5_A5A5);

        // MULT flushed at iteration 10
        bus32.start_i = 1'b1; bus32.op_i = 3'b000; bus32.rs_i = 32'd3; bus32.rt_i = 32'd4;
        tick();
        bus32.start_i = 1'b0;
        repeat (10) tick();
        bus32.flush_i = 1'b1;
        tick();
        bus32.flush_i = 1'b0;
        #1;
        check("flush idle next", 64'(bus32.busy_o), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus32.done_o) dcnt++;
            tick();
        end
        check("flush no done", 64'(dcnt), 64'd0);
        check("flush hi kept", 64'(bus32.hi_o), 64'hA5A5_A5A5);

        // Reset mid-DIV
        bus32.start_i = 1'b1; bus32.op_i = 3'b010; bus32.rs_i = 32'd100; bus32.rt_i = 32'd7;
        tick();
        bus32.start_i = 1'b0;
        repeat (5) tick();
        #1 rst = 1'b0;
        #1;
        check("rst hi", 64'(bus32.hi_o), 64'd0);
        check("rst lo", 64'(bus32.lo_o), 64'd0);
        check("rst busy", 64'(bus32.busy_o), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // WIDTH=8: signed MULT then back-to-back DIVU in the done cycle
        run8(3'b000, 8'h80, 8'h80, lat);
        check("w8 mult hi", 64'(bus8.hi_o), 64'h40);
        check("w8 mult lo", 64'(bus8.lo_o), 64'h00);
        check("w8 mult latency", 64'(lat), 64'd10);
        run8(3'b011, 8'd100, 8'd7, lat);
        check("w8 divu lo", 64'(bus8.lo_o), 64'h0E);
        check("w8 divu hi", 64'(bus8.hi_o), 64'h02);
        check("w8 divu latency", 64'(lat), 64'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mips_mdu.md
# mips_mdu

Parametrised iterative multiply/divide unit for the 5-cycle MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers. It sits beside the ALU in the execute stage. Its busy output feeds the hazard unit, which stalls MFHI/MFLO and back-to-back mul/div instructions until the result is committed.

## Interface

Parameters:
- WIDTH, 32, operand width. Applies to HI, LO, rs_i and rt_i. Must be ≥4.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- start_i  input  1  valid operation present in E stage this cycle
- op_i  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops
- rs_i  input  WIDTH  operand A (multiplicand / dividend / MTHI/MTLO source)
- rt_i  input  WIDTH  operand B (multiplier / divisor)
- flush_i  input  1  cancel the in-flight or presented operation
- busy_o  output  1  mul/div in flight or being accepted this cycle (combinational)
- done_o  output  1  one-cycle registered pulse: HI/LO just updated by a mul/div
- hi_o  output  WIDTH  HI register
- lo_o  output  WIDTH  LO register

## Operation

- FSM states:
  - IDLE: accepts a new operation.
  - MUL: runs WIDTH iterations.
  - DIV: runs WIDTH iterations.
  - FIX: applies sign correction and commits the result.
- IDLE with start_i=1, flush_i=0:
  - MULT/MULTU → MUL. DIV/DIVU → DIV.
  - Operand magnitudes, the signed flag and the result-sign flags are latched.
  - The iteration counter is cleared.
- MTHI/MTLO: writes rs_i into HI/LO at the end of the cycle. Single cycle; the FSM stays in IDLE; done_o does not pulse.
- MUL: one shift-add step per cycle on a 2·WIDTH accumulator. Goes to FIX when the counter reaches WIDTH−1.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). Goes to FIX after WIDTH steps.
- FIX:
  - Signed ops negate the product, quotient and remainder as required.
  - Remainder takes the dividend's sign; quotient takes the XOR of the operand signs.
  - Mul: HI/LO ← 2·WIDTH product. Div: LO ← quotient, HI ← remainder.
  - Next state is IDLE, and done_o goes high the following cycle.
- Divide by zero:
  - LO ← all ones, HI ← dividend, for both signed and unsigned.
  - The timing is the same as a normal divide.
- Signed overflow case, most-negative ÷ −1: LO ← most-negative, HI ← 0.
- start_i in any state other than IDLE is ignored, including MTHI/MTLO. The hazard unit guarantees this does not occur.
- Flush rules:
  - flush_i in MUL, DIV or FIX: go to IDLE next cycle. HI/LO are unchanged and there is no done_o.
  - flush_i in IDLE suppresses acceptance of start_i, including MTHI/MTLO.
  - flush_i in FIX wins over the commit.
- busy_o = (state ≠ IDLE) OR (start_i AND NOT flush_i AND op_i ∈ {MULT, MULTU, DIV, DIVU}).
- hi_o and lo_o show the committed registers at all times. Intermediate values are never visible.

## Timing

- Reset, asynchronous active-low:
  - State → IDLE.
  - HI=0, LO=0, done_o=0; counter and accumulators cleared.
  - busy_o is then driven only by start_i.
- Reset mid-operation aborts immediately. HI/LO are cleared, not preserved.
- Mul/div latency: start accepted at edge 0, then WIDTH iteration cycles, then 1 FIX cycle. HI/LO are valid and done_o=1 in cycle WIDTH+2 after the start cycle (34 for WIDTH=32).
- busy_o is high from the start cycle through the FIX cycle, which is WIDTH+2 cycles total. It is low in the done_o cycle.
- A new start is accepted in the same cycle done_o is high.
- MTHI/MTLO: the value is visible on hi_o/lo_o the cycle after start_i.
- Operands are sampled only at acceptance. Later changes on rs_i/rt_i have no effect.

## Test plan

- MULT rs=0xFFFFFFFD (−3), rt=5:
  - HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - done_o exactly 34 cycles after start.
  - busy_o high for 34 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- Signed divide cases:
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x00001234, same latency as a normal divide.
- Flush and reset during an operation:
  - MTHI 0xA5A5A5A5 sets HI=0xA5A5A5A5 with no busy_o.
  - A MULT then flushed at iteration 10 → HI stays 0xA5A5A5A5, no done_o, IDLE next cycle.
  - Reset asserted mid-DIV → HI=LO=0 and busy_o=0 immediately.
- WIDTH=8: MULT 0x80×0x80 → HI=0x40, LO=0x00, done_o 10 cycles after start. Back-to-back DIVU started in the done_o cycle is accepted.
